// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: command initiator for the Life PE array.
// Loads an initial pattern into the array with WRITE commands. Runs up to N generations with
// PROCESS commands and stops early once the array goes stable. Scans cell states back out
// over a valid/ready stream.
//
// Ports:
//   clk, rst                    system clock, asynchronous active-high reset
//   load_start/valid/data/ready pattern load stream (raster order, row-major)
//   run_start, gen_target       start a run of gen_target generations
//   read_start, rd_*            readout stream, one cell per beat in raster order
//   cmd                         PE command bus (NOP / PROCESS / WRITE)
//   rsel_i/csel_i               one-hot write selects into the PEs
//   rsel_o/csel_o               one-hot read selects into the PEs
//   array_state, array_active   OR-reduced PE state / activity from the array
//   busy, done, stable          status; done is a one-cycle pulse on return to idle
//   gens_done                   PROCESS cycles issued in the last run
module pe_array_ctrl #(
  parameter int unsigned ROWS  = 4,
  parameter int unsigned COLS  = 4,
  parameter int unsigned GEN_W = 16,
  // Command width and encodings must match the PE declarations.
  parameter int unsigned CMD_W = 2,
  parameter logic [CMD_W-1:0] PE_CMD_NOP     = CMD_W'(0),
  parameter logic [CMD_W-1:0] PE_CMD_PROCESS = CMD_W'(1),
  parameter logic [CMD_W-1:0] PE_CMD_WRITE   = CMD_W'(2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             load_valid,
  input  logic             load_data,
  output logic             load_ready,
  input  logic             run_start,
  input  logic [GEN_W-1:0] gen_target,
  input  logic             read_start,
  output logic             rd_valid,
  output logic             rd_data,
  input  logic             rd_ready,
  output logic [CMD_W-1:0] cmd,
  output logic [ROWS-1:0]  rsel_i,
  output logic [COLS-1:0]  csel_i,
  output logic [ROWS-1:0]  rsel_o,
  output logic [COLS-1:0]  csel_o,
  input  logic             array_state,
  input  logic             array_active,
  output logic             busy,
  output logic             done,
  output logic             stable,
  output logic [GEN_W-1:0] gens_done
);

  localparam int unsigned NumCells = ROWS * COLS;
  localparam int unsigned AW       = (NumCells > 1) ? $clog2(NumCells) : 1;
  localparam logic [AW-1:0] LastAddr = AW'(NumCells - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StReadAddr, StReadHold} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [GEN_W-1:0] target_q, target_d;
  logic [GEN_W-1:0] gens_q, gens_d;
  logic             stable_q, stable_d;
  logic             done_q, done_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_data_q, rd_data_d;

  logic [ROWS-1:0]  row_oh;
  logic [COLS-1:0]  col_oh;

  // load_data is wired straight to the PEs' state_in at top level.
  logic unused_load_data;
  assign unused_load_data = load_data;

  // Row-major raster decode of the cell address.
  assign row_oh = ROWS'(1) << (32'(addr_q) / COLS);
  assign col_oh = COLS'(1) << (32'(addr_q) % COLS);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    target_d   = target_q;
    gens_d     = gens_q;
    stable_d   = stable_q;
    done_d     = 1'b0;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    cmd        = PE_CMD_NOP;
    rsel_i     = '0;
    csel_i     = '0;
    rsel_o     = '0;
    csel_o     = '0;
    load_ready = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (load_start) begin
          state_d = StLoad;
          addr_d  = '0;
        end else if (run_start) begin
          state_d  = StRun;
          addr_d   = '0;
          target_d = gen_target;
          gens_d   = '0;
          stable_d = 1'b0;
        end else if (read_start) begin
          state_d = StReadAddr;
          addr_d  = '0;
        end
      end

      StLoad: begin
        load_ready = 1'b1;
        // The WRITE is only driven while a beat is offered, so the PE captures exactly the
        // handshaken beats.
        if (load_valid) begin
          cmd    = PE_CMD_WRITE;
          rsel_i = row_oh;
          csel_i = col_oh;
          if (addr_q == LastAddr) begin
            state_d = StIdle;
            done_d  = 1'b1;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
      end

      StRun: begin
        if (target_q == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cmd = PE_CMD_PROCESS;
          if (gens_q != target_q) begin
            gens_d = gens_q + GEN_W'(1);
          end
          // array_active describes the generation being computed this very cycle.
          if (!array_active) begin
            stable_d = 1'b1;
            state_d  = StIdle;
            done_d   = 1'b1;
          end else if (gens_q + GEN_W'(1) == target_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end

      StReadAddr: begin
        rsel_o     = row_oh;
        csel_o     = col_oh;
        rd_data_d  = array_state;
        rd_valid_d = 1'b1;
        state_d    = StReadHold;
      end

      StReadHold: begin
        // Keep the selects up so the captured beat and the array agree until consumed.
        rsel_o = row_oh;
        csel_o = col_oh;
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          if (addr_q == LastAddr) begin
            state_d = StIdle;
            done_d  = 1'b1;
            addr_d  = '0;
          end else begin
            addr_d  = addr_q + AW'(1);
            state_d = StReadAddr;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      target_q   <= '0;
      gens_q     <= '0;
      stable_q   <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      target_q   <= target_d;
      gens_q     <= gens_d;
      stable_q   <= stable_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign stable    = stable_q;
  assign gens_done = gens_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

endmodule
